servo_position_driver: RTL
==========================

Name: servo_position_driver

Overview:
- Downstream consumer of the arm position memory stage. Takes a position word (`greater_num`) plus a one-shot load strobe.
- Moves an internal current position toward that target one unit per step tick, then holds it.
- Emits a fixed-period servo PWM whose pulse width encodes the current position. Reports busy/done/clamped status for LEDs and the display path.

Parameters:
- DATA_WIDTH, 16, width of target and current position words
- POS_MAX, 180, largest legal position; larger targets are clamped
- RESET_POS, 90, current position after reset
- PERIOD_CYCLES, 1_000_000, PWM period in clk cycles (20 ms at 50 MHz)
- MIN_PULSE_CYCLES, 50_000, pulse width at position 0
- CYCLES_PER_UNIT, 278, pulse-width increment per position unit
- STEP_CYCLES, 500_000, clk cycles between one-unit position steps

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  single-cycle strobe; samples target
- target  in  DATA_WIDTH  requested position, unsigned
- pwm_out  out  1  servo PWM, registered
- current_pos  out  DATA_WIDTH  position currently driven, registered
- busy  out  1  high while current_pos != latched target
- done  out  1  one-cycle pulse on arrival at target
- clamped  out  1  sticky; set when a loaded target exceeded POS_MAX

Behaviour:
- Reset state (cycle after rst=1):
  - current_pos=RESET_POS, latched target=RESET_POS
  - pwm_out=0, busy=0, done=0, clamped=0
  - PWM counter=0, step timer=0, FSM=IDLE
- rst overrides load in the same cycle. Reset mid-move aborts the move immediately; no done pulse.
- Load:
  - tgt_eff = min(target, POS_MAX); latched on the load cycle.
  - clamped set if target>POS_MAX. It is cleared only by rst.
- FSM IDLE:
  - load with tgt_eff != current_pos -> MOVING. busy=1 on the next cycle; step timer cleared.
  - load with tgt_eff == current_pos -> stay IDLE; done=1 on the next cycle; busy stays 0.
- FSM MOVING:
  - Step timer counts 0..STEP_CYCLES-1. At the wrap (tick), current_pos moves by ±1 toward the target. The first step lands STEP_CYCLES cycles after busy rises.
  - When a tick makes current_pos equal the target: the following cycle has busy=0, done=1 (one cycle), FSM=IDLE.
  - load while MOVING re-targets without clearing the step timer. Direction is re-evaluated at each tick.
  - load that re-targets to exactly current_pos -> IDLE next cycle with a done pulse.
- current_pos never leaves 0..POS_MAX; no wrap-around.
- PWM:
  - Counter runs 0..PERIOD_CYCLES-1 continuously, independent of FSM state.
  - Width latched when counter==0: MIN_PULSE_CYCLES + current_pos*CYCLES_PER_UNIT. Computed at 32 bits; no overflow for legal parameters.
  - pwm_out = (counter < latched width), registered. A width change never takes effect mid-period.
  - First period after reset uses the width for RESET_POS.

Optional Feature:
- Macro: SERVO_RAMP_EN.
- Defined: stepped ramp exactly as in Behaviour.
- Undefined:
  - No step timer. A load with tgt_eff != current_pos sets current_pos=tgt_eff on the next cycle, with busy=0 and done=1 in that same cycle. busy is constant 0.
  - Clamp, PWM latching and reset behaviour are unchanged.

Test Plan:
Bench parameters: PERIOD_CYCLES=100, MIN_PULSE_CYCLES=10, CYCLES_PER_UNIT=1, POS_MAX=50, RESET_POS=25, STEP_CYCLES=4; SERVO_RAMP_EN defined unless stated.
1. Release rst, run 200 cycles -> current_pos=25, busy=0; pwm_out high exactly 35 cycles of each 100-cycle period.
2. load target=28 -> busy=1 next cycle; current_pos 26/27/28 at +4/+8/+12 cycles after busy rises; done=1 for one cycle as busy falls; next full period pulse=38.
3. load target=200 -> clamped=1, ramp stops at 50, pulse=60; further load target=10 ramps down to 10; clamped stays 1 until rst.
4. load target=25 at reset position -> busy stays 0, done pulses once the cycle after load.
5. load 40, then after 2 steps (pos=27) load 20 -> direction reverses without a timer restart; single done pulse on reaching 20; assert rst mid-ramp -> pos=25, busy=0, no done.
6. SERVO_RAMP_EN undefined: load 45 -> next cycle current_pos=45, done=1, busy=0; pwm width changes only at the next counter==0.

Source files
------------

// File: rtl/servo_position_driver.sv
// servo_position_driver: ramps a held position toward a loaded target and drives servo PWM; define SERVO_RAMP_EN for the stepped ramp, otherwise moves jump immediately
module servo_position_driver #(
  parameter int DATA_WIDTH       = 16,
  parameter int POS_MAX          = 180,
  parameter int RESET_POS        = 90,
  parameter int PERIOD_CYCLES    = 1_000_000,
  parameter int MIN_PULSE_CYCLES = 50_000,
  parameter int CYCLES_PER_UNIT  = 278,
  parameter int STEP_CYCLES      = 500_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] target,
  output logic                  pwm_out,
  output logic [DATA_WIDTH-1:0] current_pos,
  output logic                  busy,
  output logic                  done,
  output logic                  clamped
);
  localparam int CW = PERIOD_CYCLES > 1 ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [31:0] RESET_WIDTH = 32'(MIN_PULSE_CYCLES + RESET_POS * CYCLES_PER_UNIT);
  typedef enum logic {IDLE, MOVING} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pos_q, pos_d, tgt_q, tgt_d, tgt_eff, tgt_n;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           width_q, width_d;
  logic                  pwm_q, pwm_d, done_q, done_d, clamped_q, clamped_d, over;
`ifdef SERVO_RAMP_EN
  localparam int SW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  logic [SW-1:0] step_q, step_d;
  logic          tick;
`endif
  // Target clamping, sticky clamp flag, and the free-running PWM period with width latched at period start
  always_comb begin
    over      = target > DATA_WIDTH'(POS_MAX);
    tgt_eff   = over ? DATA_WIDTH'(POS_MAX) : target;
    tgt_n     = load ? tgt_eff : tgt_q;
    clamped_d = clamped_q | (load & over);
    cnt_d     = cnt_q == CW'(PERIOD_CYCLES - 1) ? '0 : cnt_q + CW'(1);
    width_d   = cnt_q == '0 ? 32'(MIN_PULSE_CYCLES) + 32'(pos_q) * 32'(CYCLES_PER_UNIT) : width_q;
    pwm_d     = 32'(cnt_q) < width_d;
  end
  // Position FSM: IDLE waits for a load; MOVING steps one unit per tick until the target is reached
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    tgt_d   = tgt_n;
    done_d  = 1'b0;
`ifdef SERVO_RAMP_EN
    tick    = step_q == SW'(STEP_CYCLES - 1);
    step_d  = step_q;
    if (state_q == IDLE) begin
      if (load && tgt_eff != pos_q) begin
        state_d = MOVING;
        step_d  = '0;
      end else if (load) begin
        done_d = 1'b1;
      end
    end else begin
      step_d = tick ? '0 : step_q + SW'(1);
      if (tgt_n == pos_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (tick) begin
        pos_d = tgt_n > pos_q ? pos_q + DATA_WIDTH'(1) : pos_q - DATA_WIDTH'(1);
        if (pos_d == tgt_n) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
`else
    if (load) begin
      pos_d  = tgt_eff;
      done_d = 1'b1;
    end
`endif
  end
  // State registers with synchronous reset to the rest position
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pos_q     <= DATA_WIDTH'(RESET_POS);
      tgt_q     <= DATA_WIDTH'(RESET_POS);
      cnt_q     <= '0;
      width_q   <= RESET_WIDTH;
      pwm_q     <= 1'b0;
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      width_q   <= width_d;
      pwm_q     <= pwm_d;
      done_q    <= done_d;
      clamped_q <= clamped_d;
    end
  end
`ifdef SERVO_RAMP_EN
  // Step timer, cleared whenever a move starts from IDLE
  always_ff @(posedge clk) begin
    if (rst) step_q <= '0;
    else     step_q <= step_d;
  end
`endif
  assign pwm_out     = pwm_q;
  assign current_pos = pos_q;
  assign busy        = state_q == MOVING;
  assign done        = done_q;
  assign clamped     = clamped_q;
endmodule
